// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier.
// Drives an N+1-bit add/subtract unit, one Booth step per cycle.

module Add_Sub_Nbit #(
  parameter int N = 33
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         k,
  output logic [N:0]   S
);

  // k=1 turns B into its two's complement: A + ~B + 1
  assign S = {1'b0, A}
           + {1'b0, B ^ {N{k}}}
           + {{N{1'b0}}, k};

endmodule

module booth_mul_seq #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N:0]    m_q;
  logic [N:0]    a_q;
  logic [N-1:0]  q_q;
  logic          q_m1;
  logic [CW-1:0] count;

  logic          add_op;
  logic          sub_op;
  logic [N+1:0]  sum;
  logic [N:0]    t_val;
  logic [N:0]    a_sh;
  logic [N-1:0]  q_sh;
  logic          last;
  logic          unused_carry;

  assign add_op = ~q_q[0] & q_m1;
  assign sub_op = q_q[0] & ~q_m1;

  Add_Sub_Nbit #(
    .N (N + 1)
  ) u_addsub (
    .A (a_q),
    .B (m_q),
    .k (sub_op),
    .S (sum)
  );

  assign unused_carry = sum[N+1];

  // Booth select: take the adder result on 01/10, pass A on 00/11
  always_comb begin
    t_val = a_q;
    unique case (1'b1)
      add_op,
      sub_op:  t_val = sum[N:0];
      default: ;
    endcase
  end

  assign a_sh = {t_val[N], t_val[N:1]};
  assign q_sh = {t_val[0], q_q[N-1:1]};
  assign last = (count == CW'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == CALC);
  end

  // Datapath: capture on accept, shift each CALC cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            m_q   <= {mcand[N-1], mcand};
            q_q   <= mplier;
            a_q   <= '0;
            q_m1  <= 1'b0;
            count <= CW'(N);
          end
        end
        CALC: begin
          a_q   <= a_sh;
          q_q   <= q_sh;
          q_m1  <= q_q[0];
          count <= count - CW'(1);
          if (last) product <= {a_sh[N-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed corners plus random
// back-to-back products against a plain-arithmetic reference.

module tb_booth_mul_seq;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int compared   = 0;
  int mismatched = 0;
  int ecount     = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  booth_mul_seq #(
    .N (N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input logic [31:0] a,
    input logic [31:0] b,
    input string       tag
  );
    int          cyc;
    int          bcnt;
    logic [63:0] exp;
    exp = ref_mul(a, b);
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
    bcnt   = busy ? 1 : 0;
    cyc    = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk({tag, "_busy"}, 64'(bcnt), 64'd32);
    chk({tag, "_prod"}, product, exp);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_hold"}, product, exp);
  endtask

  initial begin
    logic [63:0] exp;
    logic [63:0] expq[$];
    int          dones;
    int          w;
    int          last_done;

    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_prod", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'd3, 32'd5, "p3x5");
    run_op(-32'sd7, 32'd6, "m7x6");
    run_op(32'd6, -32'sd7, "p6xm7");
    run_op(-32'sd7, -32'sd6, "m7xm6");
    run_op(32'h8000_0000, 32'h8000_0000, "minxmin");
    run_op(32'h8000_0000, 32'h7FFF_FFFF, "minxmax");
    run_op(32'd0, 32'd12345, "zero_mc");
    run_op(-32'sd5, 32'd0, "zero_mp");
    chk("abs_m7x6", ref_mul(-32'sd7, 32'd6),
        64'hFFFF_FFFF_FFFF_FFD6);

    // start re-pulsed mid-operation must be ignored
    exp = ref_mul(32'd100, -32'sd3);
    @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd100;
    mplier = -32'sd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start  = 1'b1;
    mcand  = 32'd77;
    mplier = 32'd88;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        chk("ign_prod", product, exp);
      end
    end
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_idle", {63'd0, busy}, 64'd0);

    // asynchronous reset mid-calculation
    @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd1234;
    mplier = 32'd4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_prod", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(-32'sd123456, 32'd789, "post_rst");

    // random back-to-back with start held high
    last_done = -1;
    @(negedge clk);
    start  = 1'b1;
    mcand  = $urandom;
    mplier = $urandom;
    for (int i = 0; i < 50; i++) begin
      w = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
      end while (!busy && w < 100);
      chk("b2b_accept", {63'd0, busy}, 64'd1);
      expq.push_back(ref_mul(mcand, mplier));
      mcand  = $urandom;
      mplier = $urandom;
      if (i == 49) start = 1'b0;
      w = 0;
      while (!done && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk("b2b_done", {63'd0, done}, 64'd1);
      if (expq.size() > 0) chk("b2b_prod", product, expq.pop_front());
      if (last_done >= 0)
        chk("b2b_space", 64'(ecount - last_done), 64'd34);
      last_done = ecount;
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
